// File: rtl/seg_scan_decoder_if.sv
// Scanned 7-segment display bus plus the decoded readback results.
//   an_i        : anode selects, active-low, one-hot-low while a digit is driven
//   seg_i       : segment pattern, active-low, bit7 = dp, bits6..0 = g..a
//   digits_o    : decoded hex code per digit, digit k at [4k+3:4k]
//   dp_o        : captured decimal point per digit (1 = lit)
//   valid_o     : digit k holds a decoded hex value
//   frame_o     : one-cycle pulse once every digit has been captured
//   err_o       : one-cycle pulse on capture of an unrecognised pattern
//   err_digit_o : index of the digit that caused the most recent error
// master = display side / fixture driving the scan bus, slave = decoder.
interface seg_scan_decoder_if #(
    parameter int NUM_DIGITS = 8
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [NUM_DIGITS-1:0]   an_i;
    logic [7:0]              seg_i;
    logic [4*NUM_DIGITS-1:0] digits_o;
    logic [NUM_DIGITS-1:0]   dp_o;
    logic [NUM_DIGITS-1:0]   valid_o;
    logic                    frame_o;
    logic                    err_o;
    logic [IDX_W-1:0]        err_digit_o;

    modport master (
        output an_i, seg_i,
        input  digits_o, dp_o, valid_o, frame_o, err_o, err_digit_o
    );

    modport slave (
        input  an_i, seg_i,
        output digits_o, dp_o, valid_o, frame_o, err_o, err_digit_o
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Readback decoder for a time-multiplexed, active-low 7-segment bus.
// Each anode strobe is qualified as stable for STABLE_CYCLES identical
// samples, then the segment pattern is mapped back to a hex code for the
// strobed digit.
//   clk_i : system clock, rising edge
//   rst_i : synchronous, active-high reset
//   bus   : seg_scan_decoder_if slave (scan inputs and decoded outputs)
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    seg_scan_decoder_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // The capture edge is the one on which cnt would reach STABLE_CYCLES-1,
    // i.e. the STABLE_CYCLES-th identical sample in a row.
    localparam logic [CNT_W-1:0] CAP_CNT  = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, QUAL, HOLD} state_t;

    // Returns {hit, blank, code}.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'b1000000: decode_seg = {2'b10, 4'h0};
            7'b1111001: decode_seg = {2'b10, 4'h1};
            7'b0100100: decode_seg = {2'b10, 4'h2};
            7'b0110000: decode_seg = {2'b10, 4'h3};
            7'b0011001: decode_seg = {2'b10, 4'h4};
            7'b0010010: decode_seg = {2'b10, 4'h5};
            7'b0000010: decode_seg = {2'b10, 4'h6};
            7'b1111000: decode_seg = {2'b10, 4'h7};
            7'b0000000: decode_seg = {2'b10, 4'h8};
            7'b0011000: decode_seg = {2'b10, 4'h9};
            7'b0001000: decode_seg = {2'b10, 4'hA};
            7'b0000011: decode_seg = {2'b10, 4'hB};
            7'b1000110: decode_seg = {2'b10, 4'hC};
            7'b0100001: decode_seg = {2'b10, 4'hD};
            7'b0000110: decode_seg = {2'b10, 4'hE};
            7'b0001110: decode_seg = {2'b10, 4'hF};
            7'b1111111: decode_seg = {2'b01, 4'h0};
            default:    decode_seg = 6'b0;
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] zero_index(input logic [NUM_DIGITS-1:0] an);
        zero_index = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) zero_index = IDX_W'(i);
        end
    endfunction

    logic [NUM_DIGITS-1:0]   an_q, an_prev;
    logic [7:0]              seg_q, seg_prev;
    logic [CNT_W-1:0]        cnt;
    state_t                  state;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp, valid, seen;
    logic                    frame, err;
    logic [IDX_W-1:0]        err_digit;

    logic                    onehot, match, capture;
    logic [5:0]              dec;
    logic [IDX_W-1:0]        idx;
    logic [NUM_DIGITS-1:0]   cap_mask;

    assign onehot   = $onehot(~an_q);
    assign match    = onehot && (an_q == an_prev) && (seg_q == seg_prev);
    assign capture  = match && (state != HOLD) && (cnt == CAP_CNT);
    assign dec      = decode_seg(seg_q[6:0]);
    assign idx      = zero_index(an_q);
    // an_q is one-hot-low whenever capture is set, so its inverse is the digit mask.
    assign cap_mask = capture ? ~an_q : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            an_q      <= '1;
            seg_q     <= '1;
            an_prev   <= '1;
            seg_prev  <= '1;
            cnt       <= '0;
            state     <= IDLE;
            digits    <= '0;
            dp        <= '0;
            valid     <= '0;
            seen      <= '0;
            frame     <= 1'b0;
            err       <= 1'b0;
            err_digit <= '0;
        end else begin
            an_q     <= bus.an_i;
            seg_q    <= bus.seg_i;
            an_prev  <= an_q;
            seg_prev <= seg_q;
            err      <= 1'b0;
            frame    <= &seen;
            // A capture landing on the clearing cycle keeps its seen bit.
            seen     <= ((&seen) ? '0 : seen) | cap_mask;

            if (!onehot) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (!match) begin
                state <= QUAL;
                cnt   <= '0;
            end else if (state == HOLD) begin
                cnt   <= LAST_CNT;
            end else if (capture) begin
                state <= HOLD;
                cnt   <= LAST_CNT;
                dp[idx] <= ~seg_q[7];
                if (dec[5]) begin
                    digits[4*idx +: 4] <= dec[3:0];
                    valid[idx]         <= 1'b1;
                end else begin
                    valid[idx] <= 1'b0;
                    if (!dec[4]) begin
                        err       <= 1'b1;
                        err_digit <= idx;
                    end
                end
            end else begin
                state <= QUAL;
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.digits_o    = digits;
    assign bus.dp_o        = dp;
    assign bus.valid_o     = valid;
    assign bus.frame_o     = frame;
    assign bus.err_o       = err;
    assign bus.err_digit_o = err_digit;
endmodule
